// File: rtl/vga_timing_pipe.sv
// ---------------------------------------------------------------------------
// vga_timing_pipe
//
// Pixel-timing and DAC output stage of the VGA path. It runs on the pixel
// clock. Free-running horizontal and vertical counters produce sync and
// blanking. The stage requests each active pixel from an upstream source
// that has a fixed 1-cycle read latency. The returned colour is registered
// into the DAC outputs so that it lines up exactly with sync and blank.
//
// Ports:
//   CLK          in   1   pixel clock
//   RST          in   1   asynchronous, active-high reset
//   PIX_REQ      out  1   counter position lies in the active area
//   PIX_X        out  XW  horizontal counter (driven during blanking as well)
//   PIX_Y        out  YW  vertical counter (driven during blanking as well)
//   FRAME_START  out  1   high for the single cycle at (0,0)
//   PIX_R/G/B    in   10  upstream colour, valid one cycle after PIX_REQ
//   VGA_HS       out  1   horizontal sync, active low
//   VGA_VS       out  1   vertical sync, active low
//   VGA_BLANK    out  1   1 = active video, 0 = blank (DAC BLANK_N)
//   VGA_R/G/B    out  10  DAC colour, forced to 0 outside active video
// ---------------------------------------------------------------------------
module vga_timing_pipe #(
  parameter int HDISP  = 640,
  parameter int HFP    = 16,
  parameter int HPULSE = 96,
  parameter int HBP    = 48,
  parameter int VDISP  = 480,
  parameter int VFP    = 11,
  parameter int VPULSE = 2,
  parameter int VBP    = 31,
  parameter int XW     = 11,
  parameter int YW     = 10
) (
  input  logic          CLK,
  input  logic          RST,
  output logic          PIX_REQ,
  output logic [XW-1:0] PIX_X,
  output logic [YW-1:0] PIX_Y,
  output logic          FRAME_START,
  input  logic [9:0]    PIX_R,
  input  logic [9:0]    PIX_G,
  input  logic [9:0]    PIX_B,
  output logic          VGA_HS,
  output logic          VGA_VS,
  output logic          VGA_BLANK,
  output logic [9:0]    VGA_R,
  output logic [9:0]    VGA_G,
  output logic [9:0]    VGA_B
);

  localparam int HTOTAL = HDISP + HFP + HPULSE + HBP;
  localparam int VTOTAL = VDISP + VFP + VPULSE + VBP;

  // The boundary constants are one bit wider than the counters. A boundary
  // that equals 2**XW (or 2**YW) then stays representable and does not wrap
  // to zero.
  localparam logic [XW:0] H_LAST     = (XW+1)'(HTOTAL - 1);
  localparam logic [XW:0] H_ACT_END  = (XW+1)'(HDISP);
  localparam logic [XW:0] HS_START   = (XW+1)'(HDISP + HFP);
  localparam logic [XW:0] HS_END     = (XW+1)'(HDISP + HFP + HPULSE);
  localparam logic [YW:0] V_LAST     = (YW+1)'(VTOTAL - 1);
  localparam logic [YW:0] V_ACT_END  = (YW+1)'(VDISP);
  localparam logic [YW:0] VS_START   = (YW+1)'(VDISP + VFP);
  localparam logic [YW:0] VS_END     = (YW+1)'(VDISP + VFP + VPULSE);

  logic [XW-1:0] hc;
  logic [YW-1:0] vc;
  logic [XW:0]   hc_ext;
  logic [YW:0]   vc_ext;
  logic          h_last;
  logic          v_last;
  logic          h_active;
  logic          v_active;
  logic          active;
  logic          hs_n;
  logic          vs_n;

  logic          hs_d;
  logic          vs_d;
  logic          act_d;

  // Position counters. vc advances only when hc wraps. Because of that,
  // vertical sync changes on line boundaries, at hc = 0.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hc <= '0;
      vc <= '0;
    end else if (h_last) begin
      hc <= '0;
      if (v_last) begin
        vc <= '0;
      end else begin
        vc <= vc + 1'b1;
      end
    end else begin
      hc <= hc + 1'b1;
    end
  end

  // Combinational decode of the current counter state. This is the request
  // stage, and it is what the upstream pixel source sees this cycle.
  always_comb begin
    hc_ext   = {1'b0, hc};
    vc_ext   = {1'b0, vc};
    h_last   = (hc_ext == H_LAST);
    v_last   = (vc_ext == V_LAST);
    h_active = (hc_ext < H_ACT_END);
    v_active = (vc_ext < V_ACT_END);
    active   = h_active && v_active;
    hs_n     = !((hc_ext >= HS_START) && (hc_ext < HS_END));
    vs_n     = !((vc_ext >= VS_START) && (vc_ext < VS_END));
  end

  assign PIX_REQ     = active;
  assign PIX_X       = hc;
  assign PIX_Y       = vc;
  assign FRAME_START = (hc == '0) && (vc == '0);

  // Stage 1 holds the timing decode for one cycle. During that cycle the
  // upstream source fetches the colour for the same position.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      hs_d  <= 1'b1;
      vs_d  <= 1'b1;
      act_d <= 1'b0;
    end else begin
      hs_d  <= hs_n;
      vs_d  <= vs_n;
      act_d <= active;
    end
  end

  // Stage 2 registers sync, blank and colour together, so all DAC outputs
  // share the same 2-cycle latency. Colour is gated by the delayed active
  // flag. Data from upstream during blanking (often undefined) therefore
  // never reaches the DAC.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      VGA_HS    <= 1'b1;
      VGA_VS    <= 1'b1;
      VGA_BLANK <= 1'b0;
      VGA_R     <= '0;
      VGA_G     <= '0;
      VGA_B     <= '0;
    end else begin
      VGA_HS    <= hs_d;
      VGA_VS    <= vs_d;
      VGA_BLANK <= act_d;
      VGA_R     <= act_d ? PIX_R : '0;
      VGA_G     <= act_d ? PIX_G : '0;
      VGA_B     <= act_d ? PIX_B : '0;
    end
  end

endmodule

// File: tb/tb_vga_timing_pipe.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_pipe
//
// Bench for vga_timing_pipe. Horizontal timing uses the real 640-pixel line.
// The vertical timing is shortened (8 active lines, 15 lines per frame), so
// that several complete frames, the vertical sync and a mid-frame reset all
// fit in a short run.
//
// Stimulus pushes the expected request-stage and DAC values into queues.
// A monitor on the falling edge pops and compares them every cycle.
// ---------------------------------------------------------------------------
module tb_vga_timing_pipe;

  localparam int HDISP  = 640;
  localparam int HFP    = 16;
  localparam int HPULSE = 96;
  localparam int HBP    = 48;
  localparam int VDISP  = 8;
  localparam int VFP    = 2;
  localparam int VPULSE = 2;
  localparam int VBP    = 3;
  localparam int XW     = 11;
  localparam int YW     = 10;

  // Hand-derived timing for the parameters above.
  localparam int HTOTAL   = 800;
  localparam int VTOTAL   = 15;
  localparam int FRAME    = 12000;
  localparam int HS_START = 656;
  localparam int HS_END   = 752;
  localparam int VS_START = 10;
  localparam int VS_END   = 12;
  localparam int HS_LOW   = 96;
  localparam int VS_LOW   = 1600;

  typedef struct {
    logic        req;
    logic [10:0] x;
    logic [9:0]  y;
    logic        fs;
  } req_t;

  typedef struct {
    logic       hs;
    logic       vs;
    logic       blank;
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } dac_t;

  typedef struct {
    logic hs;
    logic vs;
    logic act;
    int   x;
    int   y;
  } stage_t;

  logic          clk_sig;
  logic          rst;
  logic          pix_req;
  logic [XW-1:0] pix_x;
  logic [YW-1:0] pix_y;
  logic          frame_start;
  logic [9:0]    pix_r;
  logic [9:0]    pix_g;
  logic [9:0]    pix_b;
  logic          vga_hs;
  logic          vga_vs;
  logic          vga_blank;
  logic [9:0]    vga_r;
  logic [9:0]    vga_g;
  logic [9:0]    vga_b;

  int checks = 0;
  int errors = 0;

  req_t   req_q[$];
  dac_t   dac_q[$];
  stage_t prev;
  stage_t p1;
  stage_t p2;
  int     mhc;
  int     mvc;
  logic   mon_on = 1'b0;

  req_t mon_r;
  dac_t mon_d;
  int   hs_run  = 0;
  int   vs_run  = 0;
  int   vs_runs = 0;
  int   fs_seen = 0;
  int   cyc     = 0;
  int   last_fs = -1;

  vga_timing_pipe #(
    .HDISP (HDISP),
    .HFP   (HFP),
    .HPULSE(HPULSE),
    .HBP   (HBP),
    .VDISP (VDISP),
    .VFP   (VFP),
    .VPULSE(VPULSE),
    .VBP   (VBP),
    .XW    (XW),
    .YW    (YW)
  ) dut (
    .CLK        (clk_sig),
    .RST        (rst),
    .PIX_REQ    (pix_req),
    .PIX_X      (pix_x),
    .PIX_Y      (pix_y),
    .FRAME_START(frame_start),
    .PIX_R      (pix_r),
    .PIX_G      (pix_g),
    .PIX_B      (pix_b),
    .VGA_HS     (vga_hs),
    .VGA_VS     (vga_vs),
    .VGA_BLANK  (vga_blank),
    .VGA_R      (vga_r),
    .VGA_G      (vga_g),
    .VGA_B      (vga_b)
  );

  initial clk_sig = 1'b0;
  always #5 clk_sig = ~clk_sig;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Returns the model to the post-reset state. Any expectations still queued
  // from before the reset are discarded.
  task automatic resetModel();
    stage_t rs;
    rs.hs = 1'b1; rs.vs = 1'b1; rs.act = 1'b0; rs.x = 0; rs.y = 0;
    prev = rs;
    p1   = rs;
    p2   = rs;
    mhc  = 0;
    mvc  = 0;
    req_q.delete();
    dac_q.delete();
  endtask

  // Runs one pixel cycle. It drives the upstream data for the previous
  // request (or 3FF during blanking) and queues the expected outputs for
  // this cycle. It then moves to the next cycle.
  task automatic applyStimulus();
    stage_t     cur;
    req_t       r;
    dac_t       d;
    logic [9:0] xv;
    logic [9:0] yv;
    if (prev.act) begin
      xv    = prev.x[9:0];
      yv    = prev.y[9:0];
      pix_r = xv;
      pix_g = yv;
      pix_b = ~xv;
    end else begin
      pix_r = 10'h3FF;
      pix_g = 10'h3FF;
      pix_b = 10'h3FF;
    end
    cur.x   = mhc;
    cur.y   = mvc;
    cur.act = (mhc < HDISP) && (mvc < VDISP);
    cur.hs  = !((mhc >= HS_START) && (mhc < HS_END));
    cur.vs  = !((mvc >= VS_START) && (mvc < VS_END));
    r.req = cur.act;
    r.x   = mhc[10:0];
    r.y   = mvc[9:0];
    r.fs  = (mhc == 0) && (mvc == 0);
    req_q.push_back(r);
    xv      = p2.x[9:0];
    yv      = p2.y[9:0];
    d.hs    = p2.hs;
    d.vs    = p2.vs;
    d.blank = p2.act;
    d.r     = p2.act ? xv : 10'h000;
    d.g     = p2.act ? yv : 10'h000;
    d.b     = p2.act ? ~xv : 10'h000;
    dac_q.push_back(d);
    p2   = p1;
    p1   = cur;
    prev = cur;
    @(posedge clk_sig);
    #1;
    if (mhc == HTOTAL - 1) begin
      mhc = 0;
      mvc = (mvc == VTOTAL - 1) ? 0 : mvc + 1;
    end else begin
      mhc = mhc + 1;
    end
  endtask

  // Monitor: compares every cycle away from the active edge. It also
  // measures sync pulse widths and the spacing of frame starts.
  always @(negedge clk_sig) begin
    if (mon_on) begin
      if (req_q.size() > 0) begin
        mon_r = req_q.pop_front();
        checkOutput("pix_req", 32'(pix_req), 32'(mon_r.req));
        checkOutput("pix_x", 32'(pix_x), 32'(mon_r.x));
        checkOutput("pix_y", 32'(pix_y), 32'(mon_r.y));
        checkOutput("frame_start", 32'(frame_start), 32'(mon_r.fs));
      end
      if (dac_q.size() > 0) begin
        mon_d = dac_q.pop_front();
        checkOutput("vga_hs", 32'(vga_hs), 32'(mon_d.hs));
        checkOutput("vga_vs", 32'(vga_vs), 32'(mon_d.vs));
        checkOutput("vga_blank", 32'(vga_blank), 32'(mon_d.blank));
        checkOutput("vga_r", 32'(vga_r), 32'(mon_d.r));
        checkOutput("vga_g", 32'(vga_g), 32'(mon_d.g));
        checkOutput("vga_b", 32'(vga_b), 32'(mon_d.b));
      end
      if (vga_hs === 1'b0) begin
        hs_run++;
      end else if (hs_run > 0) begin
        checkOutput("hs_width", 32'(hs_run), 32'(HS_LOW));
        hs_run = 0;
      end
      if (vga_vs === 1'b0) begin
        vs_run++;
      end else if (vs_run > 0) begin
        checkOutput("vs_width", 32'(vs_run), 32'(VS_LOW));
        vs_runs++;
        vs_run = 0;
      end
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          checkOutput("fs_period", 32'(cyc - last_fs), 32'(FRAME));
        end
        last_fs = cyc;
        fs_seen++;
      end
      cyc++;
    end else begin
      hs_run  = 0;
      vs_run  = 0;
      cyc     = 0;
      last_fs = -1;
    end
  end

  initial begin
    #5_000_000;
    $display("[TB] FAIL watchdog expired actual=timeout required=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rst   = 1'b1;
    pix_r = 10'h3FF;
    pix_g = 10'h3FF;
    pix_b = 10'h3FF;
    resetModel();
    repeat (3) @(posedge clk_sig);
    #1;
    checkOutput("rst_vga_hs", 32'(vga_hs), 32'd1);
    checkOutput("rst_vga_vs", 32'(vga_vs), 32'd1);
    checkOutput("rst_vga_blank", 32'(vga_blank), 32'd0);
    checkOutput("rst_vga_r", 32'(vga_r), 32'd0);
    checkOutput("rst_vga_g", 32'(vga_g), 32'd0);
    checkOutput("rst_vga_b", 32'(vga_b), 32'd0);
    checkOutput("rst_pix_x", 32'(pix_x), 32'd0);
    checkOutput("rst_pix_y", 32'(pix_y), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("rel_pix_req", 32'(pix_req), 32'd1);
    checkOutput("rel_frame_start", 32'(frame_start), 32'd1);

    // Two full frames, then run on to (300,5) in the third frame.
    mon_on = 1'b1;
    for (int i = 0; i < 2 * FRAME + 5 * HTOTAL + 300; i++) begin
      applyStimulus();
    end
    mon_on = 1'b0;
    req_q.delete();
    dac_q.delete();
    checkOutput("pre_rst_x", 32'(pix_x), 32'd300);
    checkOutput("pre_rst_y", 32'(pix_y), 32'd5);

    // The reset is asserted between clock edges. The outputs must clear
    // before the next edge arrives.
    #2;
    rst = 1'b1;
    #1;
    checkOutput("mid_rst_vga_hs", 32'(vga_hs), 32'd1);
    checkOutput("mid_rst_vga_vs", 32'(vga_vs), 32'd1);
    checkOutput("mid_rst_vga_blank", 32'(vga_blank), 32'd0);
    checkOutput("mid_rst_vga_r", 32'(vga_r), 32'd0);
    checkOutput("mid_rst_vga_g", 32'(vga_g), 32'd0);
    checkOutput("mid_rst_vga_b", 32'(vga_b), 32'd0);
    checkOutput("mid_rst_pix_x", 32'(pix_x), 32'd0);
    checkOutput("mid_rst_pix_y", 32'(pix_y), 32'd0);
    @(posedge clk_sig);
    #1;
    rst = 1'b0;
    #1;
    checkOutput("rerel_pix_x", 32'(pix_x), 32'd0);
    checkOutput("rerel_pix_y", 32'(pix_y), 32'd0);
    checkOutput("rerel_frame_start", 32'(frame_start), 32'd1);
    checkOutput("rerel_pix_req", 32'(pix_req), 32'd1);
    resetModel();
    mon_on = 1'b1;
    for (int i = 0; i < FRAME + 2000; i++) begin
      applyStimulus();
    end
    mon_on = 1'b0;

    checkOutput("vs_pulse_count", 32'(vs_runs), 32'd3);
    checkOutput("frame_start_count", 32'(fs_seen), 32'd5);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_pipe.md
Name: vga_timing_pipe

Overview:
- Pixel-timing and output stage of the VGA path, clocked by the pixel clock (CLK_AUX at top level).
- Free-running H/V counters generate sync and blanking.
- Issues a pixel request with X/Y coordinates to the upstream pixel source (pattern generator or frame buffer, 1-cycle read latency).
- Registers the returned RGB into the DAC outputs, aligned with sync and blank.

Parameters:
HDISP, 640, active pixels per line
VDISP, 480, active lines per frame
HFP, 16, horizontal front porch (pixels)
HPULSE, 96, horizontal sync width (pixels)
HBP, 48, horizontal back porch (pixels)
VFP, 11, vertical front porch (lines)
VPULSE, 2, vertical sync width (lines)
VBP, 31, vertical back porch (lines)
XW, 11, width of PIX_X; 2**XW must be >= HTOTAL
YW, 10, width of PIX_Y; 2**YW must be >= VTOTAL

Ports:
CLK  in  1  pixel clock
RST  in  1  reset, asynchronous, active-high
PIX_REQ  out  1  current counter position is in the active area
PIX_X  out  XW  horizontal counter hc
PIX_Y  out  YW  vertical counter vc
FRAME_START  out  1  high for one cycle when hc==0 and vc==0
PIX_R, PIX_G, PIX_B  in  10 each  upstream pixel data, valid 1 cycle after PIX_REQ
VGA_HS  out  1  horizontal sync, active low
VGA_VS  out  1  vertical sync, active low
VGA_BLANK  out  1  1 = active video, 0 = blank (DAC BLANK_N)
VGA_R, VGA_G, VGA_B  out  10 each  DAC colour data

Behaviour:
- Interface: one clock, CLK. Reset RST is asynchronous and active-high. All flops clear on posedge RST.
- Derived constants:
  - HTOTAL = HDISP+HFP+HPULSE+HBP (800).
  - VTOTAL = VDISP+VFP+VPULSE+VBP (524).
- Counters:
  - hc increments every cycle; wraps HTOTAL-1 -> 0.
  - On that wrap, vc increments; vc wraps VTOTAL-1 -> 0.
  - Reset value: hc = vc = 0.
- Line layout, active first:
  - hc in [0, HDISP) active.
  - Then front porch.
  - hs_n = 0 for hc in [HDISP+HFP, HDISP+HFP+HPULSE), i.e. 656..751 at default.
  - Then back porch.
- Frame layout:
  - vc in [0, VDISP) active.
  - vs_n = 0 for vc in [VDISP+VFP, VDISP+VFP+VPULSE), i.e. lines 491..492. Low for whole lines, transitions aligned with hc = 0.
- Request stage (combinational decode of counter registers, cycle t):
  - PIX_REQ = (hc < HDISP) && (vc < VDISP).
  - PIX_X = hc, PIX_Y = vc, always driven, including in blanking.
  - FRAME_START = (hc == 0) && (vc == 0).
  - Upstream presents the RGB for (PIX_X, PIX_Y) on PIX_R/G/B during cycle t+1.
- Stage 1 (edge ending cycle t): hs_d, vs_d, act_d <= hs_n, vs_n, PIX_REQ.
- Stage 2 (edge ending cycle t+1):
  - VGA_HS <= hs_d, VGA_VS <= vs_d, VGA_BLANK <= act_d.
  - VGA_R/G/B <= act_d ? PIX_R/G/B : 0.
- Latency: 2 cycles from counter state to DAC outputs, identical for sync, blank and colour, so relative alignment is exact.
- Reset values:
  - VGA_HS = 1, VGA_VS = 1, VGA_BLANK = 0, VGA_R/G/B = 0.
  - Stage-1 regs: hs_d = vs_d = 1, act_d = 0.
- After RST deasserts, the first cycle has hc = vc = 0, with PIX_REQ = 1 and FRAME_START = 1.
- Reset mid-frame: counters and pipeline return to reset values immediately (async). The frame restarts at (0,0); no partial-state carry-over.
- Colour masking: RGB outputs are forced to 0 whenever VGA_BLANK will be 0, regardless of PIX_* inputs (X or non-zero data must not leak).
- No back-pressure. Upstream must honour the fixed 1-cycle latency.

Test Plan:
1. Assert RST for 3 cycles with PIX_* = 10'h3FF -> VGA_HS = VGA_VS = 1, VGA_BLANK = 0, VGA_R/G/B = 0, PIX_X = PIX_Y = 0; first cycle after release: PIX_REQ = 1, FRAME_START = 1.
2. Run one line from release -> PIX_REQ high 640 cycles, low 160; VGA_BLANK rises exactly 2 cycles after PIX_REQ and stays high 640 cycles; PIX_X counts 0..799 then 0 with PIX_Y = 1.
3. Check HS -> VGA_HS low for 96 cycles starting 2 cycles after PIX_X = 656, every line, period 800.
4. Run 2 full frames -> FRAME_START period 419200 cycles; VGA_VS low for 1600 cycles (lines 491–492), starting 2 cycles after (hc = 0, vc = 491); PIX_REQ never high for vc >= 480.
5. Upstream model returning {PIX_R, PIX_G, PIX_B} = {PIX_X[9:0], PIX_Y, ~PIX_X[9:0]} with 1-cycle delay; drive 10'h3FF during blanking -> VGA_R equals x of the pixel for all 640 active cycles, and all RGB = 0 whenever VGA_BLANK = 0.
6. Assert RST at (hc = 300, vc = 200) for 1 cycle -> outputs return to reset values asynchronously; after release, PIX_X = 0, PIX_Y = 0, FRAME_START = 1, and HS/VS timing matches scenario 3/4 from the new origin.
